// File: rtl/noc_pkg.sv
// noc_pkg: shared flit layout helpers and FSM state types for the node
// interface.
//   bus_size()       : flit width, {valid, dest, payload}
//   flit_valid_bit() : bit index of the flit valid bit
//   flit_addr_lsb()  : lowest bit of the destination field
//   tx_state_t       : TX handshake states (sender side)
//   rx_state_t       : RX handshake states (receiver side)
package noc_pkg;

  function automatic int bus_size(input int data_size, input int addr_size);
    return data_size + addr_size + 1;
  endfunction

  function automatic int flit_valid_bit(input int data_size, input int addr_size);
    return data_size + addr_size;
  endfunction

  function automatic int flit_addr_lsb(input int data_size);
    return data_size;
  endfunction

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_REQ  = 2'd1,
    T_REL  = 2'd2
  } tx_state_t;

  typedef enum logic {
    R_WAIT = 1'b0,
    R_ACK  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/ni_rx_fifo.sv
// ni_rx_fifo: first-word-fall-through FIFO holding received payloads.
//   clk, a_rst : clock, synchronous active-high reset (empties the FIFO)
//   i_push     : write i_data (ignored when full unless a pop frees the slot)
//   i_pop      : drop the head (ignored when empty)
//   o_valid    : FIFO not empty; o_data is the head word
//   o_full     : all 2^LOG2 slots occupied
module ni_rx_fifo #(
  parameter int W    = 32,
  parameter int LOG2 = 2
) (
  input  logic         clk,
  input  logic         a_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_full
);
  localparam int DEPTH = 1 << LOG2;

  logic [W-1:0]  r_mem [DEPTH];
  // One extra pointer bit separates full from empty when the indexes match.
  logic [LOG2:0] r_wptr, r_rptr;
  logic          w_empty, w_do_push, w_do_pop;

  assign w_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[LOG2] != r_rptr[LOG2]) &&
                     (r_wptr[LOG2-1:0] == r_rptr[LOG2-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  // At full, a same-cycle pop vacates the head slot, which is exactly where
  // the write lands; the head is read combinationally before the edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_valid = !w_empty;
  assign o_data  = r_mem[r_rptr[LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[LOG2-1:0]] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (LOG2+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (LOG2+1)'(1);
    end
  end

endmodule

// File: rtl/net_iface.sv
// net_iface: node-side end of a switch local port.
//   Host TX  : tx_valid/tx_ready/tx_dest/tx_data -> flit {1,dest,data}
//   Host RX  : rx_valid/rx_ready/rx_data from a small FWFT FIFO
//   Switch   : sw_wr_ready_out/sw_r_ready_in/sw_data_o (we send, 4-phase)
//              sw_wr_ready_in/sw_r_ready_out/sw_data_i (we receive, 4-phase)
//   Status   : tx_count/rx_count (wrapping), tx_err/rx_err (sticky)
//   clk, a_rst : clock, synchronous active-high reset
module net_iface import noc_pkg::*; #(
  parameter  int DATA_SIZE = 32,
  parameter  int ADDR_SIZE = 4,
  parameter  int NODES_NUM = 9,
  parameter  int ADDR      = 0,
  parameter  int RX_LOG2   = 2,
  parameter  int CNT_W     = 16,
  localparam int BUS_SIZE  = bus_size(DATA_SIZE, ADDR_SIZE)
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [ADDR_SIZE-1:0] tx_dest,
  input  logic [DATA_SIZE-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 sw_wr_ready_out,
  input  logic                 sw_r_ready_in,
  output logic [BUS_SIZE-1:0]  sw_data_o,
  input  logic                 sw_wr_ready_in,
  output logic                 sw_r_ready_out,
  input  logic [BUS_SIZE-1:0]  sw_data_i,
  output logic [CNT_W-1:0]     tx_count,
  output logic [CNT_W-1:0]     rx_count,
  output logic                 tx_err,
  output logic                 rx_err
);
  localparam int VB = flit_valid_bit(DATA_SIZE, ADDR_SIZE);
  localparam int AL = flit_addr_lsb(DATA_SIZE);

  tx_state_t           r_tx_state, w_tx_next;
  rx_state_t           r_rx_state, w_rx_next;
  logic [BUS_SIZE-1:0] r_flit, w_tx_flit;
  logic [CNT_W-1:0]    r_tx_cnt, r_rx_cnt;
  logic                r_tx_err, r_rx_err;
  logic                w_accept, w_dest_ok, w_capture, w_flit_ok, w_push;
  logic                w_fifo_full;

  // ---------------- TX ----------------
  assign tx_ready  = (r_tx_state == T_IDLE) && !a_rst;
  assign w_accept  = tx_valid && tx_ready;
  assign w_dest_ok = int'(tx_dest) < NODES_NUM;

  always_comb begin
    w_tx_flit                    = '0;
    w_tx_flit[VB]                = 1'b1;
    w_tx_flit[AL +: ADDR_SIZE]   = tx_dest;
    w_tx_flit[DATA_SIZE-1:0]     = tx_data;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    unique case (r_tx_state)
      T_IDLE:  if (w_accept && w_dest_ok) w_tx_next = T_REQ;
      T_REQ:   if (sw_r_ready_in)         w_tx_next = T_REL;
      T_REL:   if (!sw_r_ready_in)        w_tx_next = T_IDLE;
      default:                            w_tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      r_tx_state <= T_IDLE;
      r_flit     <= '0;
      r_tx_cnt   <= '0;
      r_tx_err   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_accept && w_dest_ok)  r_flit   <= w_tx_flit;
      if (w_accept && !w_dest_ok) r_tx_err <= 1'b1;
      // A flit counts as sent once the switch has latched it.
      if (r_tx_state == T_REQ && sw_r_ready_in) r_tx_cnt <= r_tx_cnt + CNT_W'(1);
    end
  end

  // ---------------- RX ----------------
  // Capture only with room in the FIFO; otherwise r stays low and the switch
  // keeps holding its flit.
  assign w_capture = (r_rx_state == R_WAIT) && sw_wr_ready_in && !w_fifo_full;
  assign w_flit_ok = sw_data_i[VB] && (sw_data_i[AL +: ADDR_SIZE] == ADDR_SIZE'(ADDR));
  assign w_push    = w_capture && w_flit_ok;

  always_comb begin
    w_rx_next = r_rx_state;
    unique case (r_rx_state)
      R_WAIT: if (w_capture)       w_rx_next = R_ACK;
      R_ACK:  if (!sw_wr_ready_in) w_rx_next = R_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      r_rx_state <= R_WAIT;
      r_rx_cnt   <= '0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      if (w_push)                r_rx_cnt <= r_rx_cnt + CNT_W'(1);
      if (w_capture && !w_flit_ok) r_rx_err <= 1'b1;
    end
  end

  ni_rx_fifo #(.W(DATA_SIZE), .LOG2(RX_LOG2)) u_fifo (
    .clk     (clk),
    .a_rst   (a_rst),
    .i_push  (w_push),
    .i_data  (sw_data_i[DATA_SIZE-1:0]),
    .i_pop   (rx_ready),
    .o_valid (rx_valid),
    .o_data  (rx_data),
    .o_full  (w_fifo_full)
  );

  assign sw_wr_ready_out = (r_tx_state == T_REQ);
  assign sw_r_ready_out  = (r_rx_state == R_ACK);
  assign sw_data_o       = r_flit;
  assign tx_count        = r_tx_cnt;
  assign rx_count        = r_rx_cnt;
  assign tx_err          = r_tx_err;
  assign rx_err          = r_rx_err;

endmodule
